// File: rtl/hanning_window.sv
// Captures one N-sample frame, scales each sample by a Q0.8 Hanning coefficient
// and streams the windowed frame out over a valid/ready handshake.
module hanning_window #(
    parameter int N      = 32,
    parameter int DATA_W = 7,
    parameter int COEF_W = 8
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_dropped
);
    localparam int IDX_W  = $clog2(N);
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(1 << (COEF_W - 1));

    // Half-window table, tabulated for N = 32: round(255 * 0.5 * (1 - cos(2*pi*n/31))).
    localparam logic [COEF_W-1:0] COEF_TAB [N/2] = '{
        8'd0,   8'd3,   8'd10,  8'd23,  8'd40,  8'd60,  8'd83,  8'd108,
        8'd134, 8'd159, 8'd184, 8'd206, 8'd224, 8'd239, 8'd249, 8'd254
    };

    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

    state_t                   state, state_nxt;
    logic [IDX_W-1:0]         wr_idx, rd_idx, wr_addr;
    logic signed [DATA_W-1:0] sample_buf [N];
    logic signed [DATA_W-1:0] win_sample;
    logic                     accept, load, last_xfer;

    // For a power-of-two N, N-1-n is ~n, so the mirrored index is the low bits inverted.
    function automatic logic [COEF_W-1:0] coef_rom(input logic [IDX_W-1:0] n);
        return COEF_TAB[n[IDX_W-1] ? ~n[IDX_W-2:0] : n[IDX_W-2:0]];
    endfunction

    function automatic logic signed [DATA_W-1:0] window_round(
        input logic signed [DATA_W-1:0] x,
        input logic [COEF_W-1:0]        w
    );
        logic signed [PROD_W-1:0] xe, we;
        xe = {{(PROD_W-DATA_W){x[DATA_W-1]}}, x};
        we = {{(PROD_W-COEF_W){1'b0}}, w};
        return DATA_W'((xe * we + ROUND_HALF) >>> COEF_W);
    endfunction

    assign in_ready   = (state == FILL);
    assign accept     = in_valid && in_ready;
    assign last_xfer  = out_valid && out_ready && out_last;
    // Once the last beat is loaded, nothing more is fetched for this frame.
    assign load       = (state == EMIT) && (!out_valid || (out_ready && !out_last));
    assign wr_addr    = frame_start ? '0 : wr_idx;
    assign win_sample = window_round(sample_buf[rd_idx], coef_rom(rd_idx));

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = FILL;
            FILL:    if (accept && !frame_start && wr_idx == LAST_IDX) state_nxt = EMIT;
            EMIT:    if (last_xfer) state_nxt = frame_start ? FILL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (accept) sample_buf[wr_addr] <= $signed(in_data);
    end

    // Output register stage: loads from the buffer whenever the downstream slot is free.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            wr_idx        <= '0;
            rd_idx        <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_first     <= 1'b0;
            out_last      <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            frame_dropped <= (state == EMIT) && frame_start && !last_xfer;

            if (state != FILL)    wr_idx <= '0;
            else if (frame_start) wr_idx <= accept ? IDX_W'(1) : '0;
            else if (accept)      wr_idx <= wr_idx + IDX_W'(1);

            if (state != EMIT) rd_idx <= '0;
            else if (load)     rd_idx <= rd_idx + IDX_W'(1);

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= win_sample;
                out_first <= (rd_idx == '0);
                out_last  <= (rd_idx == LAST_IDX);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hanning_window.sv
// Bench for hanning_window: directed frames with random data, checked against a
// floating-point window model and a queue of observed output beats.
module tb_hanning_window;
    localparam int N      = 32;
    localparam int DATA_W = 7;
    localparam int COEF_W = 8;

    logic              Clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_first;
    logic              out_last;
    logic              out_ready = 1'b0;
    logic              frame_dropped;

    hanning_window #(.N(N), .DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
        .Clk(Clk), .reset(reset), .frame_start(frame_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_first(out_first), .out_last(out_last), .out_ready(out_ready),
        .frame_dropped(frame_dropped)
    );

    always #5 Clk = ~Clk;

    typedef struct { int data; bit first; bit last; int cyc; } beat_t;

    beat_t           beats[$];
    int              tests = 0;
    int              fails = 0;
    int              cyc = 0;
    int              drops = 0;
    int              last_acc_cyc = 0;
    int              wref[N/2];
    int              frame_in[N];
    bit              prev_stall = 1'b0;
    logic [DATA_W+1:0] prev_out = '0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_out(input int x, input int n);
        int w;
        w = wref[(n < N/2) ? n : N-1-n];
        return int'($floor((x * w + 128) / 256.0));
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin : monitor
        beat_t b;
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", int'({out_valid, out_first, out_last, out_data}),
                      int'({1'b1, prev_out}));
            if (out_valid && out_ready) begin
                b.data  = int'($signed(out_data));
                b.first = out_first;
                b.last  = out_last;
                b.cyc   = cyc;
                beats.push_back(b);
            end
            if (frame_dropped) drops <= drops + 1;
            prev_stall <= out_valid && !out_ready;
            prev_out   <= {out_first, out_last, out_data};
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fill_frame(input bit do_start, input int first);
        int i = first;
        int guard = 0;
        if (do_start) begin
            frame_start = 1'b1;
            in_valid    = 1'b1;
            in_data     = '1;
            tick();
            frame_start = 1'b0;
        end
        while (i < N && guard < 200) begin
            in_valid = 1'b1;
            in_data  = frame_in[i][DATA_W-1:0];
            if (in_ready) begin
                last_acc_cyc = cyc;
                i++;
            end
            tick();
            guard++;
        end
        in_valid = 1'b0;
        check("fill_accepts", i, N);
    endtask

    task automatic wait_beats(input int n, input bit rand_ready, input string tag);
        int k = 0;
        while (beats.size() < n && k < 1000) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        out_ready = 1'b1;
        repeat (3) tick();
        check(tag, beats.size(), n);
    endtask

    task automatic check_frame(input int base, input string tag);
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (base + i < beats.size()) b = beats[base + i];
            else b = '{999, 1'b0, 1'b0, 0};
            check({tag, "_data"},  b.data, model_out(frame_in[i], i));
            check({tag, "_first"}, int'(b.first), int'(i == 0));
            check({tag, "_last"},  int'(b.last), int'(i == N-1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  int'(in_ready), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_first"}, int'(out_first), 0);
        check({tag, "_out_last"},  int'(out_last), 0);
        check({tag, "_dropped"},   int'(frame_dropped), 0);
        check({tag, "_out_data"},  int'(out_data), 0);
    endtask

    task automatic random_frame();
        for (int i = 0; i < N; i++) frame_in[i] = int'($urandom_range(0, 127)) - 64;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin : stimulus
        real pi;
        int  k, n0, d0;
        pi = 3.14159265358979;
        for (int n = 0; n < N/2; n++)
            wref[n] = int'($floor(255.0 * 0.5 * (1.0 - $cos(2.0 * pi * n / (N - 1))) + 0.5));

        // reset state
        #12;
        check_idle_outputs("reset");
        tick();
        reset = 1'b0;

        // constant positive frame, free-running sink
        for (int i = 0; i < N; i++) frame_in[i] = 63;
        beats.delete();
        out_ready = 1'b1;
        fill_frame(1'b1, 0);
        wait_beats(N, 1'b0, "t1_count");
        check_frame(0, "t1");
        check("t1_latency", beats[0].cyc - last_acc_cyc, 2);
        check("t1_burst", beats[N-1].cyc - beats[0].cyc, N - 1);
        check("t1_mid", beats[15].data, 63);
        check("t1_edge", beats[0].data, 0);

        // negative full scale
        for (int i = 0; i < N; i++) frame_in[i] = -64;
        beats.delete();
        fill_frame(1'b1, 0);
        wait_beats(N, 1'b0, "t2_count");
        check_frame(0, "t2");

        // random data with random backpressure
        random_frame();
        beats.delete();
        fill_frame(1'b1, 0);
        wait_beats(N, 1'b1, "t3_count");
        check_frame(0, "t3");

        // frame_start during EMIT is dropped
        random_frame();
        beats.delete();
        d0 = drops;
        out_ready = 1'b1;
        fill_frame(1'b1, 0);
        k = 0;
        while (!out_valid && k < 20) begin tick(); k++; end
        check("t4_emit_seen", int'(out_valid), 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t4_drop_pulse", int'(frame_dropped), 1);
        tick();
        check("t4_drop_clear", int'(frame_dropped), 0);
        wait_beats(N, 1'b0, "t4_count");
        check_frame(0, "t4");
        check("t4_drops", drops - d0, 1);

        // restart during FILL after 10 samples
        beats.delete();
        d0 = drops;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom_range(0, 127));
            tick();
        end
        random_frame();
        frame_start = 1'b1;
        in_valid    = 1'b1;
        in_data     = frame_in[0][DATA_W-1:0];
        check("t5_restart_ready", int'(in_ready), 1);
        tick();
        frame_start = 1'b0;
        fill_frame(1'b0, 1);
        wait_beats(N, 1'b0, "t5_count");
        check_frame(0, "t5");
        check("t5_drops", drops - d0, 0);

        // back-to-back: frame_start on the final out_last transfer
        random_frame();
        beats.delete();
        d0 = drops;
        fill_frame(1'b1, 0);
        k = 0;
        while (!(out_valid && out_last) && k < 100) begin tick(); k++; end
        check("t6_last_seen", int'(out_valid && out_last), 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t6_in_ready", int'(in_ready), 1);
        check("t6_countA", beats.size(), N);
        check_frame(0, "t6a");
        random_frame();
        fill_frame(1'b0, 0);
        wait_beats(2 * N, 1'b0, "t6_countB");
        check_frame(N, "t6b");
        check("t6_drops", drops - d0, 0);

        // reset in the middle of FILL
        beats.delete();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom_range(0, 127));
            tick();
        end
        #2 reset = 1'b1;
        #1 check_idle_outputs("t7");
        tick();
        reset = 1'b0;
        repeat (50) tick();
        in_valid = 1'b0;
        check("t7_no_output", beats.size(), 0);
        check("t7_idle_ready", int'(in_ready), 0);
        random_frame();
        fill_frame(1'b1, 0);
        wait_beats(N, 1'b0, "t7_recover_count");
        check_frame(0, "t7r");

        // reset in the middle of EMIT while stalled
        for (int i = 0; i < N; i++) frame_in[i] = 63;
        beats.delete();
        fill_frame(1'b1, 0);
        k = 0;
        while (beats.size() < 8 && k < 50) begin tick(); k++; end
        out_ready = 1'b0;
        tick();
        tick();
        check("t8_stalled", int'(out_valid), 1);
        n0 = beats.size();
        #2 reset = 1'b1;
        #1 check_idle_outputs("t8");
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (50) tick();
        check("t8_no_output", beats.size(), n0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
